adc_sample_conditioner: RTL and testbench
=========================================

Name: adc_sample_conditioner

Overview:
- Consumes the signed sample stream produced by the sampled-signal source, e.g. phase-current or DC-bus ADC words for the PMSM control path.
- Captures a sample on each strobe, removes a calibrated DC offset, saturates the result, and presents it with a valid pulse to the downstream transform stages (Clarke/Park, PI loops).
- Offset calibration runs on request by averaging a power-of-two number of samples while the inverter is idle.

Parameters:
WIDTH, 12, sample width in bits, signed two's complement, for both input and output
CAL_LOG2, 4, calibration averages 2^CAL_LOG2 samples (range 1..10)
IIR_SHIFT, 3, low-pass coefficient 2^-IIR_SHIFT (used only with ADC_IIR_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset: synchronous, active-high
din  in  WIDTH  signed raw sample; may change asynchronously to clk and is only valid around sample_stb
sample_stb  in  1  one-cycle strobe: din is stable this cycle and is to be captured
cal_start  in  1  one-cycle request to start offset calibration
dout  out  WIDTH  signed conditioned sample
dout_valid  out  1  one-cycle pulse: dout updated
offset  out  WIDTH  signed current offset value
cal_busy  out  1  high while calibration is in progress
cal_done  out  1  high once at least one calibration has completed
ovf  out  1  sticky: saturation has occurred; cleared by reset or cal_start

Behaviour:
- Reset values (clk edge with rst=1): dout=0, dout_valid=0, offset=0, cal_busy=0, cal_done=0, ovf=0, state=IDLE, accumulator=0, sample counter=0.
- Capture: on a cycle with sample_stb=1, din is registered into x_r. Capture occurs in every state.
- States:
  - IDLE: uncalibrated; conditioning runs with offset=0.
  - CAL: accumulating samples.
  - DIV: one cycle; computes the offset.
  - RUN: calibrated; conditioning runs with the stored offset.
- Transitions:
  - IDLE or RUN + cal_start goes to CAL: accumulator and counter cleared, cal_busy=1, ovf cleared.
  - CAL: each captured sample is added to the accumulator (WIDTH+CAL_LOG2 bits, sign-extended). When the counter reaches 2^CAL_LOG2 captures, go to DIV.
  - DIV: offset = accumulator >>> CAL_LOG2 (arithmetic shift, floor toward -inf). Then go to RUN, cal_busy=0, cal_done=1.
  - cal_start while in CAL or DIV is ignored.
- Conditioning (IDLE/RUN only):
  - Compute diff = x_r - offset in WIDTH+1 bits.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. On clipping, set ovf=1.
  - dout is registered.
- Latency: sample_stb at cycle N leads to dout_valid=1 at cycle N+2, dout holding that sample's result. dout holds its value between pulses.
- Throughput: sample_stb is accepted on every cycle, back-to-back, with one dout_valid per strobe.
- During CAL/DIV:
  - dout_valid stays 0 and dout holds its last value.
  - A sample already in the pipeline when cal_start arrives still completes its output.
- A strobe coinciding with the DIV cycle is captured but neither accumulated nor output.
- rst mid-calibration aborts it: all state returns to reset values, and the partial sum is discarded.

Optional Feature:
- Macro: ADC_IIR_EN.
- When defined: a first-order low-pass follows saturation.
  - On each conditioned sample: y = y + ((sat - y) >>> IIR_SHIFT), with the difference in WIDTH+1 bits and y in WIDTH bits; dout = y.
  - y is reset to 0 by rst and by cal_start.
  - Latency becomes 3 cycles (strobe at N gives dout_valid at N+3).
- When not defined: there is no filter logic, dout is the saturated difference, and latency is 2 cycles.

Test Plan:
- Reset, then din=37 with a strobe: dout=37 and dout_valid exactly 2 cycles later; offset=0, cal_done=0.
- cal_start, then 16 strobes with din=100, then din=150: offset=100, cal_done=1, cal_busy low after DIV, dout=50.
- Calibration with 8 samples of -3 and 8 of 0 (sum -24): offset=-2 (floor of -1.5); next din=0 gives dout=2.
- Offset calibrated to -2000, then din=2047: dout=2047, ovf=1; ovf stays set until cal_start.
- rst asserted after 7 of 16 calibration samples: all outputs return to reset values; a fresh 16-sample calibration yields the correct offset.
- sample_stb high for 10 consecutive cycles in RUN: exactly 10 dout_valid pulses, in order, each with the correct value. With ADC_IIR_EN and IIR_SHIFT=3, a step from 0 to 800 gives outputs 100, 187, 263, ...

Source files
------------

// File: rtl/adc_sample_conditioner_if.sv
// rtl/adc_sample_conditioner_if.sv - sample, calibration and status signals of the ADC sample conditioner
interface adc_sample_conditioner_if #(
    parameter int WIDTH = 12
);
    logic signed [WIDTH-1:0] din;
    logic                    sample_stb;
    logic                    cal_start;
    logic signed [WIDTH-1:0] dout;
    logic                    dout_valid;
    logic signed [WIDTH-1:0] offset;
    logic                    cal_busy;
    logic                    cal_done;
    logic                    ovf;

    modport master (
        output din, sample_stb, cal_start,
        input  dout, dout_valid, offset, cal_busy, cal_done, ovf
    );

    modport slave (
        input  din, sample_stb, cal_start,
        output dout, dout_valid, offset, cal_busy, cal_done, ovf
    );
endinterface

// File: rtl/adc_sample_conditioner.sv
// rtl/adc_sample_conditioner.sv - ADC sample capture, DC offset calibration and saturation
// Optional first-order low-pass after saturation is enabled by defining ADC_IIR_EN.
module adc_sample_conditioner #(
    parameter int WIDTH    = 12,
    parameter int CAL_LOG2 = 4
`ifdef ADC_IIR_EN
    ,
    parameter int IIR_SHIFT = 3
`endif
) (
    input logic                     clk,
    input logic                     rst,
    adc_sample_conditioner_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CAL, DIV, RUN} state_t;

    localparam int ACC_W = WIDTH + CAL_LOG2;
    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CAL_LOG2-1:0] CNT_ONE = CAL_LOG2'(1);

    state_t                  state, state_next;
    logic                    cond_state, start_cal;
    logic signed [WIDTH-1:0] x_r, offset_r, dout_r, sat;
    logic                    cond_v, dout_valid_r, cal_done_r, ovf_r, clip;
    logic signed [ACC_W-1:0] acc;
    logic [CAL_LOG2-1:0]     cnt;
    logic signed [WIDTH:0]   diff;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cond_state = 1'b0;
        start_cal  = 1'b0;
        case (state)
            IDLE, RUN: begin
                cond_state = 1'b1;
                if (bus.cal_start) begin
                    start_cal  = 1'b1;
                    state_next = CAL;
                end
            end
            CAL:     if (bus.sample_stb && (&cnt)) state_next = DIV;
            DIV:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        diff = {x_r[WIDTH-1], x_r} - {offset_r[WIDTH-1], offset_r};
        clip = (diff[WIDTH] != diff[WIDTH-1]);
        sat  = clip ? (diff[WIDTH] ? SAT_MIN : SAT_MAX) : diff[WIDTH-1:0];
    end

    // cond_v tags a capture made in IDLE/RUN so it still completes after a later cal_start
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r        <= '0;
            cond_v     <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            offset_r   <= '0;
            cal_done_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            cond_v <= bus.sample_stb && cond_state;
            if (bus.sample_stb) x_r <= bus.din;
            if (start_cal) begin
                acc <= '0;
                cnt <= '0;
            end else if (state == CAL && bus.sample_stb) begin
                acc <= acc + {{CAL_LOG2{bus.din[WIDTH-1]}}, bus.din};
                cnt <= cnt + CNT_ONE;
            end
            if (state == DIV) begin
                offset_r   <= acc[ACC_W-1:CAL_LOG2];
                cal_done_r <= 1'b1;
            end
            if (start_cal)          ovf_r <= 1'b0;
            else if (cond_v && clip) ovf_r <= 1'b1;
        end
    end

`ifdef ADC_IIR_EN
    logic signed [WIDTH-1:0] sat_r, y, y_next;
    logic signed [WIDTH:0]   iir_d;
    logic                    sat_v;

    always_comb begin
        iir_d  = $signed({sat_r[WIDTH-1], sat_r}) - $signed({y[WIDTH-1], y});
        y_next = WIDTH'($signed({y[WIDTH-1], y}) + (iir_d >>> IIR_SHIFT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_r        <= '0;
            sat_v        <= 1'b0;
            y            <= '0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else begin
            sat_v        <= cond_v;
            dout_valid_r <= sat_v;
            if (cond_v) sat_r <= sat;
            if (start_cal)  y <= '0;
            else if (sat_v) y <= y_next;
            if (sat_v) dout_r <= y_next;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= cond_v;
            if (cond_v) dout_r <= sat;
        end
    end
`endif

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.offset     = offset_r;
    assign bus.cal_busy   = (state == CAL) || (state == DIV);
    assign bus.cal_done   = cal_done_r;
    assign bus.ovf        = ovf_r;
endmodule

// File: tb/tb_adc_sample_conditioner.sv
// tb/tb_adc_sample_conditioner.sv - randomized self-checking bench with a behavioural reference model
module tb_adc_sample_conditioner;
    localparam int WIDTH    = 12;
    localparam int CAL_LOG2 = 4;
    localparam int NCAL     = 1 << CAL_LOG2;
    localparam int MAXV     = (1 << (WIDTH - 1)) - 1;
    localparam int MINV     = -(1 << (WIDTH - 1));
`ifdef ADC_IIR_EN
    localparam int IIR_SHIFT = 3;
    localparam int LAT       = 3;
`else
    localparam int LAT       = 2;
`endif

    typedef struct {
        int due;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adc_sample_conditioner_if #(.WIDTH(WIDTH)) bus ();

    adc_sample_conditioner #(
        .WIDTH(WIDTH),
`ifdef ADC_IIR_EN
        .IIR_SHIFT(IIR_SHIFT),
`endif
        .CAL_LOG2(CAL_LOG2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    int  tnow = 0;
    int  phase_m, ncal_m, sum_m, off_m, done_m, ovf_m, y_m, last_val;
    ev_t outq[$];
    ev_t ovfq[$];

    task automatic check(input string tag, input integer got, input integer exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (step %0d)", tag, got, exp, tnow);
        end
    endtask

    function automatic int floor_div(input int a, input int sh);
        int n = 1 << sh;
        return (a >= 0) ? a / n : -((-a + n - 1) / n);
    endfunction

    function automatic int rnd();
        return int'($urandom_range(0, (1 << WIDTH) - 1)) + MINV;
    endfunction

    task automatic model_reset();
        phase_m = 0; ncal_m = 0; sum_m = 0; off_m = 0;
        done_m = 0; ovf_m = 0; y_m = 0; last_val = 0;
        outq.delete();
        ovfq.delete();
    endtask

    // phase_m: 0 idle/run, 1 collecting calibration samples, 2 averaging cycle
    task automatic model_apply(input bit stb, input int d, input bit cs);
        int  v;
        int  clip;
        if (phase_m == 2) begin
            off_m   = floor_div(sum_m, CAL_LOG2);
            done_m  = 1;
            phase_m = 0;
        end else if (phase_m == 1) begin
            if (stb) begin
                sum_m += d;
                ncal_m++;
                if (ncal_m == NCAL) phase_m = 2;
            end
        end else begin
            if (stb) begin
                v = d - off_m;
                clip = 0;
                if (v > MAXV) begin v = MAXV; clip = 1; end
                if (v < MINV) begin v = MINV; clip = 1; end
`ifdef ADC_IIR_EN
                y_m = y_m + floor_div(v - y_m, IIR_SHIFT);
                v = y_m;
`endif
                outq.push_back('{tnow + LAT, v});
                ovfq.push_back('{tnow + 2, clip});
            end
            if (cs) begin
                phase_m = 1; sum_m = 0; ncal_m = 0; ovf_m = 0; y_m = 0;
            end
        end
    endtask

    task automatic check_outputs();
        int ev = 0;
        if (ovfq.size() > 0 && ovfq[0].due == tnow) begin
            if (ovfq[0].val != 0) ovf_m = 1;
            void'(ovfq.pop_front());
        end
        if (outq.size() > 0 && outq[0].due == tnow) begin
            ev = 1;
            last_val = outq[0].val;
            void'(outq.pop_front());
        end
        check("dout_valid", bus.dout_valid, ev);
        check("dout", $signed(bus.dout), last_val);
        check("offset", $signed(bus.offset), off_m);
        check("cal_busy", bus.cal_busy, (phase_m != 0) ? 1 : 0);
        check("cal_done", bus.cal_done, done_m);
        check("ovf", bus.ovf, ovf_m);
    endtask

    task automatic cyc(input bit stb, input int d, input bit cs);
        logic [31:0] r;
        logic [31:0] dv;
        @(negedge clk);
        check_outputs();
        r  = $urandom;
        dv = d;
        bus.din        = stb ? dv[WIDTH-1:0] : r[WIDTH-1:0];
        bus.sample_stb = stb;
        bus.cal_start  = cs;
        model_apply(stb, d, cs);
        tnow++;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 0, 1'b0);
    endtask

    task automatic strobe(input int d);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.sample_stb = 1'b0;
        bus.cal_start  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tnow += 2;
    endtask

    // first NCAL-nb samples are a, the rest b; optional strobe on the averaging cycle
    task automatic calibrate(input int a, input int b, input int nb, input bit div_stb);
        cyc(1'b0, 0, 1'b1);
        for (int i = 0; i < NCAL; i++) begin
            if ($urandom_range(0, 3) == 0) cyc(1'b0, 0, $urandom_range(0, 1) == 1);
            strobe((i < NCAL - nb) ? a : b);
        end
        cyc(div_stb, rnd(), 1'b0);
        idle(3);
    endtask

    initial begin
        bus.din = '0;
        bus.sample_stb = 1'b0;
        bus.cal_start = 1'b0;
        model_reset();
        do_reset();

        idle(2); strobe(37); idle(4);
        calibrate(100, 0, 0, 1'b0); strobe(150); idle(4);
        calibrate(-3, 0, 8, 1'b0); strobe(0); idle(4);
        calibrate(-2000, 0, 0, 1'b0); strobe(2047); idle(2); strobe(0); idle(4);
        calibrate(0, 0, 0, 1'b1);

        cyc(1'b0, 0, 1'b1);
        repeat (7) strobe(rnd());
        do_reset();
        idle(2);
        calibrate(rnd(), rnd(), int'($urandom_range(0, NCAL)), 1'b0);

        repeat (10) strobe(rnd());
        idle(4);

        calibrate(0, 0, 0, 1'b0);
        repeat (5) strobe(800);
        idle(4);

        repeat (40) begin
            if ($urandom_range(0, 3) == 0) begin
                calibrate(rnd(), rnd(), int'($urandom_range(0, NCAL)), $urandom_range(0, 1) == 1);
            end else begin
                repeat ($urandom_range(1, 12)) cyc($urandom_range(0, 1) == 1, rnd(), 1'b0);
                idle(3);
            end
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
